// File: rtl/mcycle_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit.
// One operation in flight; a timeout turns a missing mc_done into rsp_error.
module mcycle_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_error,
  output logic             mc_start,
  output logic             mc_op,
  output logic [WIDTH-1:0] mc_a,
  output logic [WIDTH-1:0] mc_b,
  input  logic             mc_done,
  input  logic [WIDTH-1:0] mc_res1,
  input  logic [WIDTH-1:0] mc_res2
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [CW-1:0] count;
  logic          grant1;
  logic          owner_ack;

  // last=1 means req1 was served last, so req0 wins a tie
  assign grant1    = req1_valid & (~req0_valid | ~last);
  assign owner_ack = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      count      <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_error  <= 1'b0;
      mc_start   <= 1'b0;
      mc_op      <= 1'b0;
      mc_a       <= '0;
      mc_b       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_valid | req1_valid) begin
            owner      <= grant1;
            mc_op      <= grant1 ? req1_op : req0_op;
            mc_a       <= grant1 ? req1_a : req0_a;
            mc_b       <= grant1 ? req1_b : req0_b;
            mc_start   <= 1'b1;
            req0_ready <= ~grant1;
            req1_ready <= grant1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mc_start   <= 1'b0;
          req0_ready <= 1'b0;
          req1_ready <= 1'b0;
          count      <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mc_done) begin
            rsp_hi     <= mc_res1;
            rsp_lo     <= mc_res2;
            rsp_error  <= 1'b0;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else if (count == CW'(TIMEOUT - 1)) begin
            rsp_hi     <= '0;
            rsp_lo     <= '0;
            rsp_error  <= 1'b1;
            rsp0_valid <= ~owner;
            rsp1_valid <= owner;
            state      <= RESP;
          end else begin
            count <= count + CW'(1);
          end
        end
        RESP: begin
          if (owner_ack) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last       <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Bench for mcycle_arbiter: vector table, directed corner sequences
// and randomized transactions against a transaction-level model.
module tb_mcycle_arbiter;

  localparam int W  = 32;
  localparam int TO = 40;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_op;
  logic [W-1:0] req_a [2];
  logic [W-1:0] req_b [2];
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_hi, rsp_lo;
  logic         rsp_error;
  logic         mc_start, mc_op;
  logic [W-1:0] mc_a, mc_b;
  logic         mc_done;
  logic [W-1:0] mc_res1, mc_res2;

  int errors = 0;
  int checks = 0;
  bit last   = 1'b1;

  always #5 CLK = ~CLK;

  mcycle_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .req0_valid(req_valid[0]),
    .req0_op(req_op[0]),
    .req0_a(req_a[0]),
    .req0_b(req_b[0]),
    .req0_ready(req_ready[0]),
    .rsp0_valid(rsp_valid[0]),
    .rsp0_ready(rsp_ready[0]),
    .req1_valid(req_valid[1]),
    .req1_op(req_op[1]),
    .req1_a(req_a[1]),
    .req1_b(req_b[1]),
    .req1_ready(req_ready[1]),
    .rsp1_valid(rsp_valid[1]),
    .rsp1_ready(rsp_ready[1]),
    .rsp_hi(rsp_hi),
    .rsp_lo(rsp_lo),
    .rsp_error(rsp_error),
    .mc_start(mc_start),
    .mc_op(mc_op),
    .mc_a(mc_a),
    .mc_b(mc_b),
    .mc_done(mc_done),
    .mc_res1(mc_res1),
    .mc_res2(mc_res2)
  );

  typedef struct {
    int           rq;
    bit           op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           d;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Round-robin rule: a tie goes to whoever was not served last
  function automatic int winner(bit p0, bit p1);
    if (p0 && p1) return last ? 0 : 1;
    return p0 ? 0 : 1;
  endfunction

  // What the multiply/divide unit returns: {hi,lo} product or rem/quot
  function automatic void unit_result(input bit op,
                                      input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] hi,
                                      output logic [W-1:0] lo);
    logic [2*W-1:0] p;
    if (!op) begin
      p  = (2*W)'(a) * (2*W)'(b);
      hi = p[2*W-1:W];
      lo = p[W-1:0];
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  // Starts at a negedge in IDLE with requests already driven.
  // d<0 means the unit never answers.
  task automatic serve(input int w, input int d, input int hold,
                       input bit stray, input bit raise_other,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input bit eerr);
    int o;
    bit op;
    logic [W-1:0] a, b, r1, r2;
    o  = 1 - w;
    op = req_op[w];
    a  = req_a[w];
    b  = req_b[w];
    unit_result(op, a, b, r1, r2);
    step();
    chk("issue_ready_win", req_ready[w], 1);
    chk("issue_ready_other", req_ready[o], 0);
    chk("issue_mc_start", mc_start, 1);
    chk("issue_mc_op", mc_op, op);
    chk("issue_mc_a", mc_a, a);
    chk("issue_mc_b", mc_b, b);
    req_valid[w] = 1'b0;
    mc_done      = stray;
    mc_res1      = $urandom;
    mc_res2      = $urandom;
    step();
    if (raise_other) begin
      req_valid[o] = 1'b1;
      req_op[o]    = 1'($urandom);
      req_a[o]     = $urandom;
      req_b[o]     = $urandom | 32'h1;
    end
    for (int i = 0; i < TO; i++) begin
      chk("wait_mc_start", mc_start, 0);
      chk("wait_ready", req_ready, 0);
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_mc_a", mc_a, a);
      chk("wait_mc_b", mc_b, b);
      mc_done = (i == d);
      mc_res1 = (i == d) ? r1 : $urandom;
      mc_res2 = (i == d) ? r2 : $urandom;
      step();
      mc_done = 1'b0;
      if (i == d) break;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid_owner", rsp_valid[w], 1);
      chk("resp_valid_other", rsp_valid[o], 0);
      chk("resp_hi", rsp_hi, ehi);
      chk("resp_lo", rsp_lo, elo);
      chk("resp_error", rsp_error, eerr);
      chk("resp_ready", req_ready, 0);
      rsp_ready[w] = (h == hold);
      rsp_ready[o] = stray && (h < hold);
      mc_done      = stray && (h < hold);
      mc_res1      = $urandom;
      mc_res2      = $urandom;
      step();
    end
    rsp_ready = 2'b00;
    mc_done   = 1'b0;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_ready", req_ready, 0);
    chk("idle_mc_start", mc_start, 0);
    last = (w == 1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_mc_start"}, mc_start, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    logic [W-1:0] ehi, elo;
    int w, d, r;
    bit err;

    Reset     = 1'b1;
    req_valid = 2'b00;
    req_op    = 2'b00;
    rsp_ready = 2'b00;
    mc_done   = 1'b0;
    mc_res1   = '0;
    mc_res2   = '0;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end

    step();
    step();
    check_quiet("reset");
    chk("reset_mc_op", mc_op, 0);
    chk("reset_mc_a", mc_a, 0);
    chk("reset_mc_b", mc_b, 0);
    chk("reset_rsp_hi", rsp_hi, 0);
    chk("reset_rsp_lo", rsp_lo, 0);
    chk("reset_rsp_error", rsp_error, 0);
    Reset   = 1'b0;
    step();
    mc_done = 1'b1;
    mc_res1 = 32'h55;
    step();
    mc_done = 1'b0;
    step();
    check_quiet("idle_done");

    tbl[0] = '{0, 1'b0, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0};
    tbl[1] = '{1, 1'b1, 32'd100, 32'd7, 5, 32'd2, 32'd14, 1'b0};
    tbl[2] = '{0, 1'b0, 32'hFFFFFFFF, 32'd2, 0, 32'd1, 32'hFFFFFFFE, 1'b0};
    tbl[3] = '{1, 1'b1, 32'd5, 32'd9, TO - 1, 32'd5, 32'd0, 1'b0};
    tbl[4] = '{0, 1'b0, 32'd3, 32'd3, -1, 32'd0, 32'd0, 1'b1};
    tbl[5] = '{1, 1'b1, 32'd1, 32'd1, TO - 2, 32'd0, 32'd1, 1'b0};
    tbl[6] = '{0, 1'b0, 32'd12, 32'd12, 1, 32'd0, 32'd144, 1'b0};
    foreach (tbl[k]) begin
      req_valid[tbl[k].rq] = 1'b1;
      req_op[tbl[k].rq]    = tbl[k].op;
      req_a[tbl[k].rq]     = tbl[k].a;
      req_b[tbl[k].rq]     = tbl[k].b;
      serve(tbl[k].rq, tbl[k].d, 1, 1'b0, 1'b0,
            tbl[k].hi, tbl[k].lo, tbl[k].err);
    end

    // Fresh reset, then both requesters contend twice
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    last  = 1'b1;
    step();
    req_valid = 2'b11;
    req_op    = 2'b10;
    req_a[0]  = 32'd3;
    req_b[0]  = 32'd5;
    req_a[1]  = 32'd20;
    req_b[1]  = 32'd6;
    serve(0, 3, 0, 1'b0, 1'b0, 32'd0, 32'd15, 1'b0);
    req_valid[0] = 1'b1;
    serve(1, 4, 0, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);
    req_valid[1] = 1'b1;
    serve(0, 2, 0, 1'b0, 1'b0, 32'd0, 32'd15, 1'b0);
    serve(1, 2, 0, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);

    // Slow consumer on req1 with stray rsp0_ready and mc_done
    req_valid[1] = 1'b1;
    req_op[1]    = 1'b0;
    req_a[1]     = 32'd9;
    req_b[1]     = 32'd9;
    serve(1, 6, 5, 1'b1, 1'b0, 32'd0, 32'd81, 1'b0);

    // req1 arrives while req0 is in flight
    req_valid[0] = 1'b1;
    req_op[0]    = 1'b1;
    req_a[0]     = 32'd50;
    req_b[0]     = 32'd8;
    serve(0, 10, 2, 1'b0, 1'b1, 32'd2, 32'd6, 1'b0);
    unit_result(req_op[1], req_a[1], req_b[1], ehi, elo);
    serve(1, 7, 0, 1'b0, 1'b0, ehi, elo, 1'b0);

    // Reset while waiting on the unit
    req_valid[0] = 1'b1;
    req_op[0]    = 1'b0;
    req_a[0]     = 32'd4;
    req_b[0]     = 32'd4;
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    check_quiet("wait_reset");
    Reset   = 1'b0;
    last    = 1'b1;
    mc_done = 1'b1;
    mc_res2 = 32'd16;
    step();
    mc_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("post_reset");
      step();
    end

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] && $urandom_range(0, 1) == 1) begin
          req_valid[n] = 1'b1;
          req_op[n]    = 1'($urandom);
          req_a[n]     = $urandom;
          req_b[n]     = $urandom | 32'h1;
        end
      end
      if (req_valid == 2'b00) begin
        r            = $urandom_range(0, 1);
        req_valid[r] = 1'b1;
        req_op[r]    = 1'($urandom);
        req_a[r]     = $urandom;
        req_b[r]     = $urandom | 32'h1;
      end
      w = winner(req_valid[0], req_valid[1]);
      r = $urandom_range(0, 9);
      d = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, TO - 2);
      err = (d < 0);
      if (err) begin
        ehi = '0;
        elo = '0;
      end else begin
        unit_result(req_op[w], req_a[w], req_b[w], ehi, elo);
      end
      mc_done = 1'($urandom);
      mc_res1 = $urandom;
      serve(w, d, $urandom_range(0, 3), 1'($urandom), 1'b0, ehi, elo, err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcycle_arbiter.md
MCYCLE_ARBITER -- requirements
Module: mcycle_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result-half width.
REQ-002 Parameter TIMEOUT, default 40, maximum WAIT cycles before abort; SHALL exceed the unit's longest operation (WIDTH+1).
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 Reset  in  1  reset, asynchronous, active-high.
REQ-005 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-006 reqN_op  in  1  requester N operation: 0=multiply, 1=divide.
REQ-007 reqN_a, reqN_b  in  WIDTH  requester N operands.
REQ-008 reqN_ready  out  1  one-cycle acknowledge that requester N's operation is accepted.
REQ-009 rspN_valid  out  1  result available for requester N.
REQ-010 rspN_ready  in  1  requester N consumes the result.
REQ-011 rsp_hi, rsp_lo  out  WIDTH  shared result bus: product high/low, or remainder/quotient.
REQ-012 rsp_error  out  1  result aborted by timeout.
REQ-013 mc_start  out  1  one-cycle start pulse to the multi-cycle unit.
REQ-014 mc_op  out  1  operation to the unit: 0=multiply, 1=divide.
REQ-015 mc_a, mc_b  out  WIDTH  operands to the unit.
REQ-016 mc_done  in  1  one-cycle pulse from the unit; mc_res1/mc_res2 valid that cycle.
REQ-017 mc_res1, mc_res2  in  WIDTH  unit results (hi/remainder, lo/quotient).

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE, no reqN_valid: remain in IDLE.
REQ-020 IDLE, any reqN_valid: select winner, latch its op/a/b and owner index; go to ISSUE next edge.
REQ-021 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; after reset req0 has priority.
REQ-022 In ISSUE, the block SHALL assert mc_start and winner's reqN_ready for exactly one cycle, then go to WAIT.
REQ-023 A requester SHALL hold valid and operands stable until its reqN_ready; a request left valid after ready is a new request.
REQ-024 mc_op/mc_a/mc_b SHALL be driven from latched registers from ISSUE through WAIT and remain stable.
REQ-025 WAIT SHALL count cycles from 0; on mc_done, capture mc_res1->rsp_hi, mc_res2->rsp_lo, clear rsp_error, go to RESP.
REQ-026 If the WAIT count reaches TIMEOUT-1 without mc_done: rsp_hi=rsp_lo=0, rsp_error=1, go to RESP.
REQ-027 mc_done and timeout in the same cycle: mc_done wins, rsp_error=0.
REQ-028 mc_done outside WAIT SHALL be ignored.
REQ-029 In RESP, owner's rspN_valid=1, other rspN_valid=0; rsp_hi/rsp_lo/rsp_error held stable.
REQ-030 RESP holds until owner's rspN_ready=1; that edge goes to IDLE and records the owner as last granted; the non-owner's rspN_ready is ignored.
REQ-031 Requests arriving outside IDLE SHALL wait (no ready); both requests are evaluated on IDLE re-entry, one cycle after the RESP handshake.
REQ-032 Latency: valid in IDLE cycle T -> ready/mc_start in T+1 -> WAIT from T+2 -> rspN_valid the cycle after mc_done.
REQ-033 Outputs SHALL be registered; ready, mc_start, rspN_valid are never X after reset.

Reset
REQ-034 Reset SHALL force IDLE, last-grant=req1 (req0 priority), count=0, all outputs 0, in any state.
REQ-035 Reset mid-operation SHALL discard the operation with no ready/rsp pulse; mc_done after Reset release is ignored in IDLE.

Verification
REQ-036 req0 mul a=7,b=6; mc_done after 33 cycles with res1=0,res2=42 -> req0_ready one pulse with mc_start, rsp0_valid, rsp_lo=42, rsp_hi=0, rsp_error=0.
REQ-037 req0 and req1 both valid in IDLE from reset -> req0 served first, then req1; repeat -> order req0,req1 alternating.
REQ-038 mc_done never asserted -> rsp_error=1, rsp_hi=rsp_lo=0, rspN_valid exactly TIMEOUT cycles after WAIT entry.
REQ-039 rsp1_ready held low 5 cycles in RESP -> rsp1_valid and data stable 5 cycles; rsp0_ready pulse ignored; IDLE after rsp1_ready.
REQ-040 Reset asserted in WAIT, then mc_done pulse -> IDLE, no rsp valid, no ready, mc_start 0.
REQ-041 req1 valid during WAIT of req0's op -> req1_ready not asserted until after rsp0 handshake plus one cycle.
